gmem_read_arbiter: RTL and testbench
====================================

GMEM_READ_ARBITER -- requirements
Module: gmem_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, AXI master address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI master data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for N=0,1, the requester AR ports: reqN_araddr (in, ADDR_WIDTH), reqN_arlen (in, 8), reqN_arvalid (in, 1) and reqN_arready (out, 1).
REQ-006 SHALL have, for N=0,1, the requester R ports: reqN_rdata (out, DATA_WIDTH), reqN_rresp (out, 2), reqN_rlast (out, 1), reqN_rvalid (out, 1) and reqN_rready (in, 1).
REQ-007 SHALL have the master AR ports: m_axi_gmem_araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arid and arvalid (all out, standard AXI widths), plus arready (in, 1).
REQ-008 SHALL have the master R ports: m_axi_gmem_rdata, rresp, rlast, ruser, rid and rvalid (all in), plus rready (out, 1).
REQ-009 SHALL have port grant  output  2  one-hot owner of the master read channel; 00 when idle.

Function
REQ-010 SHALL implement states IDLE, ADDR and DATA, with exactly one burst outstanding at a time.
REQ-011 IDLE: when any reqN_arvalid=1, SHALL register the winner into grant and enter ADDR on the next edge; with no request, SHALL stay in IDLE.
REQ-012 Arbitration SHALL be round-robin: when both requesters are valid, the requester not granted last wins.
REQ-013 ADDR: m_axi_gmem_arvalid, araddr and arlen SHALL mux from the granted requester; the granted reqN_arready SHALL equal m_axi_gmem_arready; the other reqN_arready SHALL be 0.
REQ-014 ADDR SHALL move to DATA on the edge where m_axi_gmem_arvalid and m_axi_gmem_arready are both 1.
REQ-015 Latency: reqN_arvalid rising in IDLE at cycle 0 SHALL produce m_axi_gmem_arvalid=1 in cycle 1.
REQ-016 DATA: master rdata, rresp, rlast and rvalid SHALL route combinationally to the granted requester; m_axi_gmem_rready SHALL equal the granted reqN_rready.
REQ-017 The non-granted reqN_rvalid SHALL be 0 at all times; reqN_rdata, rresp and rlast MAY be driven from the master regardless of grant.
REQ-018 DATA SHALL return to IDLE, set grant=00 and record the last winner on the edge where rvalid, rready and rlast are all 1.
REQ-019 A beat with rvalid=1 but no rready SHALL hold state; beats with rlast=0 SHALL not end the burst.
REQ-020 Constant outputs SHALL be: arsize=log2(DATA_WIDTH/8), arburst=2'b01 (INCR), arlock=0, arcache=4'b0011, arprot=0, arqos=0, arregion=0, aruser=0, arid=0.
REQ-021 A requester SHALL hold its arvalid, araddr and arlen stable until its arready handshake; the arbiter does not re-arbitrate in ADDR or DATA.
REQ-022 A request arriving during ADDR or DATA SHALL wait and be arbitrated on the first IDLE cycle.
REQ-023 m_axi_gmem_arvalid SHALL be 0 in IDLE and DATA.

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, grant=00, m_axi_gmem_arvalid=0, m_axi_gmem_rready=0, all reqN_arready=0 and all reqN_rvalid=0.
REQ-025 Reset SHALL set last winner=1 so that requester 0 wins the first contested arbitration.
REQ-026 Reset asserted mid-burst SHALL abandon the burst without draining it; the master interface is reset alongside.

Configuration
REQ-027 With GMEM_READ_ARB_FIXED_PRIORITY_EN defined, requester 0 SHALL always win contested arbitration and last-winner tracking SHALL be omitted.
REQ-028 Without GMEM_READ_ARB_FIXED_PRIORITY_EN defined, round-robin per REQ-012 SHALL apply.

Verification
REQ-029 req0 araddr=0x1000, arlen=3 alone -> grant=01 in cycle 1; master arvalid in cycle 1; 4 beats 0xA0..0xA3 on req0; IDLE after the rlast beat.
REQ-030 req0 and req1 both valid from reset -> req0 served first, then req1; a repeat of both-valid -> req1 first (round-robin).
REQ-031 Same as REQ-030 with GMEM_READ_ARB_FIXED_PRIORITY_EN defined -> req0 always first.
REQ-032 req1 asserts arvalid during a req0 DATA burst of arlen=7 -> req1 arready=0 and rvalid=0 until req0 rlast accepted; req1 granted next IDLE cycle.
REQ-033 req0 rready toggled 1/0 each cycle during arlen=3 -> m_axi_gmem_rready mirrors it; exactly 4 beats delivered; no beat lost or duplicated.
REQ-034 reset=0 asserted after the 2nd beat of arlen=7 -> grant=00, arvalid=0, rready=0 immediately; after release a new req1 request is served normally.

Source files
------------

// File: rtl/gmem_read_arbiter.sv
// gmem_read_arbiter: two-requester AXI4 read-channel arbiter with one burst outstanding.
// Ports: clk; reset (async, active low);
//        req0_*/req1_*: requester AR (araddr, arlen, arvalid, arready) and R (rdata, rresp, rlast, rvalid, rready);
//        m_axi_gmem_*: shared AXI4 read master (AR and R channels);
//        grant: one-hot owner of the master read channel, 00 when idle.
// Option: define GMEM_READ_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins);
//         otherwise round-robin on the last completed winner.
module gmem_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] req0_araddr,
  input  logic [7:0]            req0_arlen,
  input  logic                  req0_arvalid,
  output logic                  req0_arready,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic [1:0]            req0_rresp,
  output logic                  req0_rlast,
  output logic                  req0_rvalid,
  input  logic                  req0_rready,
  input  logic [ADDR_WIDTH-1:0] req1_araddr,
  input  logic [7:0]            req1_arlen,
  input  logic                  req1_arvalid,
  output logic                  req1_arready,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [1:0]            req1_rresp,
  output logic                  req1_rlast,
  output logic                  req1_rvalid,
  input  logic                  req1_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_gmem_araddr,
  output logic [7:0]            m_axi_gmem_arlen,
  output logic [2:0]            m_axi_gmem_arsize,
  output logic [1:0]            m_axi_gmem_arburst,
  output logic                  m_axi_gmem_arlock,
  output logic [3:0]            m_axi_gmem_arcache,
  output logic [2:0]            m_axi_gmem_arprot,
  output logic [3:0]            m_axi_gmem_arqos,
  output logic [3:0]            m_axi_gmem_arregion,
  output logic                  m_axi_gmem_aruser,
  output logic                  m_axi_gmem_arid,
  output logic                  m_axi_gmem_arvalid,
  input  logic                  m_axi_gmem_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_gmem_rdata,
  input  logic [1:0]            m_axi_gmem_rresp,
  input  logic                  m_axi_gmem_rlast,
  input  logic                  m_axi_gmem_ruser,
  input  logic                  m_axi_gmem_rid,
  input  logic                  m_axi_gmem_rvalid,
  output logic                  m_axi_gmem_rready,
  output logic [1:0]            grant
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic [1:0] grant_nx;
  logic pick1, in_addr, in_data, done;
  logic unused_sigs;
  assign unused_sigs = ^{m_axi_gmem_ruser, m_axi_gmem_rid};
  assign in_addr = state == ADDR;
  assign in_data = state == DATA;
  assign done = in_data && m_axi_gmem_rvalid && m_axi_gmem_rready && m_axi_gmem_rlast;
`ifdef GMEM_READ_ARB_FIXED_PRIORITY_EN
  assign pick1 = !req0_arvalid;
`else
  // last = index of the most recently completed winner; the other side wins a contest
  logic last;
  assign pick1 = req1_arvalid && (!req0_arvalid || !last);
  always_ff @(posedge clk or negedge reset)
    if (!reset) last <= 1'b1;
    else if (done) last <= grant[1];
`endif
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    unique case (state)
      IDLE: if (req0_arvalid || req1_arvalid) begin
        state_nx = ADDR;
        grant_nx = pick1 ? 2'b10 : 2'b01;
      end
      ADDR: if (m_axi_gmem_arvalid && m_axi_gmem_arready) state_nx = DATA;
      DATA: if (done) begin
        state_nx = IDLE;
        grant_nx = 2'b00;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= 2'b00;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
    end
  assign m_axi_gmem_arvalid  = in_addr && (grant[1] ? req1_arvalid : req0_arvalid);
  assign m_axi_gmem_araddr   = grant[1] ? req1_araddr : req0_araddr;
  assign m_axi_gmem_arlen    = grant[1] ? req1_arlen : req0_arlen;
  assign m_axi_gmem_arsize   = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_gmem_arburst  = 2'b01;
  assign m_axi_gmem_arlock   = 1'b0;
  assign m_axi_gmem_arcache  = 4'b0011;
  assign m_axi_gmem_arprot   = 3'b000;
  assign m_axi_gmem_arqos    = 4'b0000;
  assign m_axi_gmem_arregion = 4'b0000;
  assign m_axi_gmem_aruser   = 1'b0;
  assign m_axi_gmem_arid     = 1'b0;
  assign req0_arready = in_addr && grant[0] && m_axi_gmem_arready;
  assign req1_arready = in_addr && grant[1] && m_axi_gmem_arready;
  assign m_axi_gmem_rready = in_data && (grant[1] ? req1_rready : req0_rready);
  assign req0_rvalid = in_data && grant[0] && m_axi_gmem_rvalid;
  assign req1_rvalid = in_data && grant[1] && m_axi_gmem_rvalid;
  assign req0_rdata = m_axi_gmem_rdata;
  assign req0_rresp = m_axi_gmem_rresp;
  assign req0_rlast = m_axi_gmem_rlast;
  assign req1_rdata = m_axi_gmem_rdata;
  assign req1_rresp = m_axi_gmem_rresp;
  assign req1_rlast = m_axi_gmem_rlast;
endmodule

// File: tb/tb_gmem_read_arbiter.sv
// tb_gmem_read_arbiter: randomized self-checking bench with a transaction-level arbiter/memory model.
module tb_gmem_read_arbiter;
  localparam int AW = 64;
  localparam int DW = 32;
`ifdef GMEM_READ_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct packed {logic [AW-1:0] addr; logic [7:0] len;} req_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [AW-1:0] r0_araddr, r1_araddr, m_araddr;
  logic [7:0] r0_arlen, r1_arlen, m_arlen;
  logic r0_arvalid, r1_arvalid, r0_arready, r1_arready;
  logic [DW-1:0] r0_rdata, r1_rdata, m_rdata;
  logic [1:0] r0_rresp, r1_rresp, m_rresp, m_arburst, grant;
  logic r0_rlast, r1_rlast, r0_rvalid, r1_rvalid, r0_rready, r1_rready;
  logic [2:0] m_arsize, m_arprot;
  logic [3:0] m_arcache, m_arqos, m_arregion;
  logic m_arlock, m_aruser, m_arid, m_arvalid, m_arready;
  logic m_rlast, m_ruser, m_rid, m_rvalid, m_rready;

  gmem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_araddr(r0_araddr), .req0_arlen(r0_arlen), .req0_arvalid(r0_arvalid), .req0_arready(r0_arready),
    .req0_rdata(r0_rdata), .req0_rresp(r0_rresp), .req0_rlast(r0_rlast), .req0_rvalid(r0_rvalid), .req0_rready(r0_rready),
    .req1_araddr(r1_araddr), .req1_arlen(r1_arlen), .req1_arvalid(r1_arvalid), .req1_arready(r1_arready),
    .req1_rdata(r1_rdata), .req1_rresp(r1_rresp), .req1_rlast(r1_rlast), .req1_rvalid(r1_rvalid), .req1_rready(r1_rready),
    .m_axi_gmem_araddr(m_araddr), .m_axi_gmem_arlen(m_arlen), .m_axi_gmem_arsize(m_arsize),
    .m_axi_gmem_arburst(m_arburst), .m_axi_gmem_arlock(m_arlock), .m_axi_gmem_arcache(m_arcache),
    .m_axi_gmem_arprot(m_arprot), .m_axi_gmem_arqos(m_arqos), .m_axi_gmem_arregion(m_arregion),
    .m_axi_gmem_aruser(m_aruser), .m_axi_gmem_arid(m_arid), .m_axi_gmem_arvalid(m_arvalid),
    .m_axi_gmem_arready(m_arready), .m_axi_gmem_rdata(m_rdata), .m_axi_gmem_rresp(m_rresp),
    .m_axi_gmem_rlast(m_rlast), .m_axi_gmem_ruser(m_ruser), .m_axi_gmem_rid(m_rid),
    .m_axi_gmem_rvalid(m_rvalid), .m_axi_gmem_rready(m_rready), .grant(grant)
  );

  int total = 0, bad = 0;
  // model: ph 0 idle / 1 address / 2 data, own = current owner, last_w = last completed winner
  int ph, own, last_w;
  int served[$];
  req_t rq0[$], rq1[$];
  logic [34:0] exp0[$], exp1[$];
  logic [DW-1:0] rx0[$], rx1[$];
  bit s_busy, s_hold, tog0;
  logic [AW-1:0] s_addr;
  logic [7:0] s_len;
  int s_cnt, ar_pct, rv_pct, rr_pct0, rr_pct1;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] addr, input int i);
    return addr[31:0] - 32'h0F60 + 32'(i);
  endfunction

  task automatic step();
    logic [1:0] eg;
    logic [34:0] act, expb;
    logic rr_own;
    req_t r;
    @(negedge clk);
    r0_arvalid = rq0.size() != 0;
    if (r0_arvalid) begin r0_araddr = rq0[0].addr; r0_arlen = rq0[0].len; end
    r1_arvalid = rq1.size() != 0;
    if (r1_arvalid) begin r1_araddr = rq1[0].addr; r1_arlen = rq1[0].len; end
    r0_rready = tog0 ? !r0_rready : ($urandom_range(99) < rr_pct0);
    r1_rready = $urandom_range(99) < rr_pct1;
    m_arready = !s_busy && ($urandom_range(99) < ar_pct);
    if (!s_hold) begin
      m_rvalid = s_busy && ($urandom_range(99) < rv_pct);
      m_rdata = beat_data(s_addr, s_cnt);
      m_rresp = 2'(s_cnt);
      m_rlast = s_cnt == int'(s_len);
    end
    #1;
    eg = ph == 0 ? 2'b00 : (own == 1 ? 2'b10 : 2'b01);
    total++;
    if (grant !== eg) begin bad++; $display("FAIL grant: got %b want %b at %0t", grant, eg, $time); end
    total++;
    if (m_arvalid !== (ph == 1)) begin bad++; $display("FAIL m_arvalid: got %b want %b at %0t", m_arvalid, ph == 1, $time); end
    if (ph == 1) begin
      r = own == 1 ? rq1[0] : rq0[0];
      total++;
      if ({m_araddr, m_arlen} !== r) begin bad++; $display("FAIL ar_mux: got %h/%0d want %h/%0d at %0t", m_araddr, m_arlen, r.addr, r.len, $time); end
    end
    total++;
    if ({r1_arready, r0_arready} !== {ph == 1 && own == 1 && m_arready, ph == 1 && own == 0 && m_arready}) begin
      bad++; $display("FAIL req_arready: got %b%b at %0t", r1_arready, r0_arready, $time);
    end
    rr_own = own == 1 ? r1_rready : r0_rready;
    total++;
    if ({r1_rvalid, r0_rvalid} !== {ph == 2 && own == 1 && m_rvalid, ph == 2 && own == 0 && m_rvalid}) begin
      bad++; $display("FAIL req_rvalid: got %b%b at %0t", r1_rvalid, r0_rvalid, $time);
    end
    total++;
    if (m_rready !== (ph == 2 && rr_own)) begin bad++; $display("FAIL m_rready: got %b want %b at %0t", m_rready, ph == 2 && rr_own, $time); end
    if (ph == 0) begin
      if (r0_arvalid || r1_arvalid) begin
        own = (r0_arvalid && r1_arvalid) ? (FIXED ? 0 : 1 - last_w) : (r0_arvalid ? 0 : 1);
        ph = 1;
      end
    end else if (ph == 1) begin
      if (m_arready) begin
        if (own == 1) r = rq1.pop_front(); else r = rq0.pop_front();
        for (int i = 0; i <= int'(r.len); i++)
          if (own == 1) exp1.push_back({i == int'(r.len), 2'(i), beat_data(r.addr, i)});
          else exp0.push_back({i == int'(r.len), 2'(i), beat_data(r.addr, i)});
        served.push_back(own);
        s_busy = 1; s_addr = m_araddr; s_len = m_arlen; s_cnt = 0; ph = 2;
      end
    end else if (m_rvalid && rr_own) begin
      act = own == 1 ? {r1_rlast, r1_rresp, r1_rdata} : {r0_rlast, r0_rresp, r0_rdata};
      expb = 'x;
      if (own == 1 && exp1.size() != 0) expb = exp1.pop_front();
      if (own == 0 && exp0.size() != 0) expb = exp0.pop_front();
      total++;
      if (act !== expb) begin bad++; $display("FAIL beat req%0d: got %h want %h at %0t", own, act, expb, $time); end
      if (own == 1) rx1.push_back(r1_rdata); else rx0.push_back(r0_rdata);
      s_hold = 0; s_cnt++;
      if (m_rlast) begin ph = 0; last_w = own; s_busy = 0; end
    end else s_hold = m_rvalid;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    rq0.delete(); rq1.delete(); exp0.delete(); exp1.delete(); rx0.delete(); rx1.delete(); served.delete();
    ph = 0; own = 0; last_w = 1; s_busy = 0; s_hold = 0; s_cnt = 0; tog0 = 0;
    m_rvalid = 0; m_arready = 0; r0_arvalid = 0; r1_arvalid = 0; r0_rready = 0; r1_rready = 0;
    ar_pct = 100; rv_pct = 100; rr_pct0 = 100; rr_pct1 = 100;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((ph != 0 || rq0.size() != 0 || rq1.size() != 0) && n < budget) begin step(); n++; end
    total++;
    if (ph != 0 || rq0.size() != 0 || rq1.size() != 0) begin bad++; $display("FAIL %s timeout: busy after %0d cycles, required idle", name, n); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    r0_araddr = '0; r1_araddr = '0; r0_arlen = '0; r1_arlen = '0;
    r0_arvalid = 1; r1_arvalid = 1; r0_rready = 1; r1_rready = 1;
    m_arready = 1; m_rvalid = 1; m_rdata = '0; m_rresp = '0; m_rlast = 1; m_ruser = 0; m_rid = 0;
    #3;
    total++;
    if ({grant, m_arvalid, m_rready, r0_arready, r1_arready, r0_rvalid, r1_rvalid} !== 8'b0) begin
      bad++; $display("FAIL reset_outputs: got grant=%b arv=%b rr=%b ar=%b%b rv=%b%b, required all 0",
        grant, m_arvalid, m_rready, r1_arready, r0_arready, r1_rvalid, r0_rvalid);
    end
    total++;
    if ({m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arregion, m_aruser, m_arid}
        !== {3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ar_constants: got size=%0d burst=%b cache=%b", m_arsize, m_arburst, m_arcache);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({grant, m_arvalid} !== 3'b0) begin bad++; $display("FAIL reset_hold: got grant=%b arvalid=%b, required 0", grant, m_arvalid); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    rq0.push_back('{64'h1000, 8'd3});
    step();
    step();
    total++;
    if ({grant, m_arvalid} !== 3'b011) begin bad++; $display("FAIL single_latency: got grant=%b arvalid=%b want 01/1", grant, m_arvalid); end
    drain(50, "single");
    total++;
    if (rx0.size() != 4) begin bad++; $display("FAIL single_count: got %0d beats want 4", rx0.size()); end
    for (int i = 0; i < rx0.size(); i++) begin
      total++;
      if (rx0[i] !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL single_data[%0d]: got %h want %h", i, rx0[i], 32'hA0 + 32'(i)); end
    end
    step();
    total++;
    if (grant !== 2'b00) begin bad++; $display("FAIL single_idle: got grant=%b want 00", grant); end
  endtask

  task automatic test_round_robin();
    int want[3];
    apply_reset();
    ar_pct = 60; rv_pct = 70;
    rq0.push_back('{64'h3000, 8'd1});
    rq0.push_back('{64'h3100, 8'd2});
    rq1.push_back('{64'h4000, 8'd2});
    drain(300, "round_robin");
    want = FIXED ? '{0, 0, 1} : '{0, 1, 0};
    total++;
    if (served.size() != 3) begin bad++; $display("FAIL rr_count: got %0d bursts want 3", served.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (served[i] != want[i]) begin bad++; $display("FAIL rr_order[%0d]: got req%0d want req%0d", i, served[i], want[i]); end
    end
  endtask

  task automatic test_wait_during_burst();
    int n = 0;
    apply_reset();
    rq0.push_back('{64'h5000, 8'd7});
    while (ph != 2 && n < 20) begin step(); n++; end
    rq1.push_back('{64'h6000, 8'd1});
    drain(100, "wait_burst");
    total++;
    if (served.size() != 2 || served[0] != 0 || served[1] != 1) begin
      bad++; $display("FAIL wait_order: got %0d bursts, first req%0d, required req0 then req1", served.size(), served.size() ? served[0] : -1);
    end
    total++;
    if (rx0.size() != 8 || rx1.size() != 2) begin bad++; $display("FAIL wait_beats: got %0d/%0d want 8/2", rx0.size(), rx1.size()); end
  endtask

  task automatic test_rready_toggle();
    apply_reset();
    tog0 = 1;
    rq0.push_back('{64'h7000, 8'd3});
    drain(60, "toggle");
    tog0 = 0;
    total++;
    if (rx0.size() != 4 || exp0.size() != 0) begin bad++; $display("FAIL toggle_beats: got %0d beats, %0d missing, want 4/0", rx0.size(), exp0.size()); end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    apply_reset();
    rq0.push_back('{64'h8000, 8'd7});
    while (rx0.size() < 2 && n < 30) begin step(); n++; end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({grant, m_arvalid, m_rready, r0_rvalid, r1_rvalid, r0_arready, r1_arready} !== 8'b0) begin
      bad++; $display("FAIL mid_reset: got grant=%b arv=%b rr=%b rv=%b%b, required all 0", grant, m_arvalid, m_rready, r1_rvalid, r0_rvalid);
    end
    apply_reset();
    rq1.push_back('{64'h2000, 8'd2});
    drain(60, "after_reset");
    total++;
    if (served.size() != 1 || served[0] != 1 || rx1.size() != 3) begin
      bad++; $display("FAIL after_reset: got %0d bursts, %0d beats, want 1 req1 burst of 3", served.size(), rx1.size());
    end
  endtask

  task automatic test_random();
    int b0 = 0, b1 = 0;
    req_t r;
    apply_reset();
    ar_pct = $urandom_range(30, 100); rv_pct = $urandom_range(30, 100);
    rr_pct0 = $urandom_range(30, 100); rr_pct1 = $urandom_range(30, 100);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(99) < 8) begin
        r.addr = {$urandom, $urandom};
        r.len = 8'($urandom_range(0, 15));
        if ($urandom_range(1) == 1) begin rq1.push_back(r); b1 += int'(r.len) + 1; end
        else begin rq0.push_back(r); b0 += int'(r.len) + 1; end
      end
      step();
    end
    drain(5000, "random");
    total++;
    if (rx0.size() != b0 || rx1.size() != b1 || exp0.size() != 0 || exp1.size() != 0) begin
      bad++; $display("FAIL random_beats: got %0d/%0d want %0d/%0d", rx0.size(), rx1.size(), b0, b1);
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wait_during_burst();
    test_rready_toggle();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
